audio_arbiter: RTL

AUDIO_ARBITER -- requirements
Module: audio_arbiter

---
 rtl/audio_pkg.sv | 44 ++++
 rtl/edge_pulse.sv | 24 ++
 rtl/audio_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg -- shared types for the audio arbiter.
//   sound_id_t  : identifies the sound being played; its numeric value is also
//                 its priority (LOSE > WIN > JUMP > NONE).
//   arb_state_t : sequencer states.
//   top_pending : highest-priority class among the pending bits.
//   clear_mask  : pending bits that a grant of a given class retires.
// Pending vectors are indexed by (sound_id - 1): bit0 = JUMP, bit1 = WIN, bit2 = LOSE.
package audio_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        JUMP = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } sound_id_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    function automatic sound_id_t top_pending(input logic [2:0] pend);
        sound_id_t id;
        id = NONE;
        if (pend[2])      id = LOSE;
        else if (pend[1]) id = WIN;
        else if (pend[0]) id = JUMP;
        return id;
    endfunction

    // A grant retires its own request and every lower-priority one.
    function automatic logic [2:0] clear_mask(input sound_id_t id);
        logic [2:0] m;
        case (id)
            LOSE:    m = 3'b111;
            WIN:     m = 3'b011;
            JUMP:    m = 3'b001;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// edge_pulse -- registered rising-edge detector.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   level : request level to watch
//   pulse : high for the cycle where level is 1 and was 0 at the previous edge
// The previous-value register resets to 1 so a level already high when reset
// releases is not mistaken for a new request.
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= level;
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/audio_arbiter.sv
// audio_arbiter -- picks one game sound at a time, times it, and muxes its tone.
//   clk, rst_n                         : clock, asynchronous active-low reset
//   jump_fwd/back/right/left           : jump request levels (ORed)
//   win, lose                          : game-event request levels
//   mute                               : forces sound to 0, sequencing continues
//   jump_tone, win_tone, lose_tone     : square waves from the tone generators
//   en_jump, en_win, en_lose           : tone generator enables (one-hot or zero)
//   active_id                          : sound now playing (NONE outside PLAY)
//   busy                               : sequencer not idle
//   sound                              : muxed audio output
// Requests are edge detected into one-deep pending bits. From IDLE the highest
// pending class is granted; while playing, only a strictly higher class may
// preempt. A finished sound is followed by GAP cycles of silence.
module audio_arbiter
    import audio_pkg::*;
#(
    parameter int DUR_JUMP = 12_500_000,
    parameter int DUR_WIN  = 50_000_000,
    parameter int DUR_LOSE = 50_000_000,
    parameter int GAP      = 1_250_000,
    parameter int CNT_W    = 26
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      jump_fwd,
    input  logic      jump_back,
    input  logic      jump_right,
    input  logic      jump_left,
    input  logic      win,
    input  logic      lose,
    input  logic      mute,
    input  logic      jump_tone,
    input  logic      win_tone,
    input  logic      lose_tone,
    output logic      en_jump,
    output logic      en_win,
    output logic      en_lose,
    output sound_id_t active_id,
    output logic      busy,
    output logic      sound
);

    localparam logic [CNT_W-1:0] LOAD_JUMP = CNT_W'(DUR_JUMP - 1);
    localparam logic [CNT_W-1:0] LOAD_WIN  = CNT_W'(DUR_WIN - 1);
    localparam logic [CNT_W-1:0] LOAD_LOSE = CNT_W'(DUR_LOSE - 1);
    localparam logic [CNT_W-1:0] LOAD_GAP  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    function automatic logic [CNT_W-1:0] load_of(input sound_id_t id);
        logic [CNT_W-1:0] v;
        case (id)
            LOSE:    v = LOAD_LOSE;
            WIN:     v = LOAD_WIN;
            default: v = LOAD_JUMP;
        endcase
        return v;
    endfunction

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       pending;
    logic [2:0]       pending_next;
    logic [2:0]       edges;
    sound_id_t        best;
    logic             grant;
    logic             jump_any;

    assign jump_any = jump_fwd | jump_back | jump_right | jump_left;

    edge_pulse u_edge_jump (.clk(clk), .rst_n(rst_n), .level(jump_any), .pulse(edges[0]));
    edge_pulse u_edge_win  (.clk(clk), .rst_n(rst_n), .level(win),      .pulse(edges[1]));
    edge_pulse u_edge_lose (.clk(clk), .rst_n(rst_n), .level(lose),     .pulse(edges[2]));

    assign best  = top_pending(pending);
    // Grant from IDLE on anything pending; from PLAY only on strictly higher priority.
    assign grant = ((state == ST_IDLE) && (best != NONE)) ||
                   ((state == ST_PLAY) && (2'(best) > 2'(active_id)));

    // Edge sets are applied after the grant clear so a request arriving in the
    // grant cycle survives and replays later.
    always_comb begin
        pending_next = pending;
        if (grant) pending_next = pending_next & ~clear_mask(best);
        pending_next = pending_next | edges;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            active_id <= NONE;
            cnt       <= '0;
            pending   <= '0;
        end else begin
            pending <= pending_next;
            if (grant) begin
                state     <= ST_PLAY;
                active_id <= best;
                cnt       <= load_of(best);
            end else begin
                case (state)
                    ST_PLAY: begin
                        if (cnt == '0) begin
                            active_id <= NONE;
                            if (GAP > 0) begin
                                state <= ST_GAP;
                                cnt   <= LOAD_GAP;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (cnt == '0) state <= ST_IDLE;
                        else           cnt   <= cnt - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy    = (state != ST_IDLE);
    assign en_jump = (state == ST_PLAY) && (active_id == JUMP);
    assign en_win  = (state == ST_PLAY) && (active_id == WIN);
    assign en_lose = (state == ST_PLAY) && (active_id == LOSE);

    always_comb begin
        sound = 1'b0;
        if ((state == ST_PLAY) && !mute) begin
            case (active_id)
                JUMP:    sound = jump_tone;
                WIN:     sound = win_tone;
                LOSE:    sound = lose_tone;
                default: sound = 1'b0;
            endcase
        end
    end

endmodule
